// File: rtl/stack_pkg.sv
// Shared definitions for the operand stack: default geometry and the
// resolved operation encoding produced from the push/pop strobes.
package stack_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 4;
    localparam int DEF_DEPTH  = 1 << DEF_ADDR_W;

    typedef enum logic [1:0] {
        OP_NONE = 2'b00,
        OP_PUSH = 2'b01,
        OP_POP  = 2'b10,
        OP_REPL = 2'b11
    } stack_op_t;

    // Storage-side effect of a strobe pair; tos never moves sp and is handled
    // as a pure read by the caller.
    function automatic stack_op_t resolve_op(
        input logic push,
        input logic pop,
        input logic empty,
        input logic full
    );
        if (push && pop && !empty) begin
            return OP_REPL;
        end else if (push && !full) begin
            return OP_PUSH;
        end else if (pop && !empty) begin
            return OP_POP;
        end
        return OP_NONE;
    endfunction

endpackage

// File: rtl/stack_regfile.sv
// Stack storage: DEPTH x DATA_W register array with one synchronous write
// port and one asynchronous read port. Contents are not reset.
module stack_regfile
    import stack_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_reg [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_reg[waddr] <= wdata;
        end
    end

    // Read sees pre-edge contents, so a same-cycle write to the read entry
    // is not forwarded.
    assign rdata = mem_reg[raddr];

endmodule

// File: rtl/stack_unit.sv
// LIFO operand stack for the stack-machine datapath: push/pop/tos strobes,
// registered read data, count/empty/full decode and sticky error flags.
module stack_unit
    import stack_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic              tos,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic [ADDR_W:0]   count,
    output logic              empty,
    output logic              full,
    output logic              overflow,
    output logic              underflow
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] SP_FULL = (ADDR_W + 1)'(DEPTH);

    logic [ADDR_W:0]   sp_reg;
    logic [ADDR_W:0]   sp_next;
    logic [DATA_W-1:0] dout_reg;
    logic              overflow_reg;
    logic              underflow_reg;

    stack_op_t         op;
    logic [ADDR_W-1:0] top_addr;
    logic [ADDR_W-1:0] wr_addr;
    logic              wr_en;
    logic              rd_en;
    logic              ovf_set;
    logic              udf_set;
    logic [DATA_W-1:0] rd_data;

    assign empty     = (sp_reg == '0);
    assign full      = (sp_reg == SP_FULL);
    assign count     = sp_reg;
    assign dout      = dout_reg;
    assign overflow  = overflow_reg;
    assign underflow = underflow_reg;

    always_comb begin
        op       = resolve_op(push, pop, empty, full);
        top_addr = ADDR_W'(sp_reg - 1'b1);
        wr_en    = (op == OP_PUSH) || (op == OP_REPL);
        wr_addr  = (op == OP_REPL) ? top_addr : sp_reg[ADDR_W-1:0];
        // Any read request on a non-empty stack returns the pre-edge top,
        // including replace and push-with-tos.
        rd_en    = !empty && (pop || tos);
        udf_set  = empty && (pop || tos);
        // Replace is legal at full, so only a push without pop overflows.
        ovf_set  = push && !pop && full;
        sp_next  = sp_reg;
        case (op)
            OP_PUSH: sp_next = sp_reg + 1'b1;
            OP_POP:  sp_next = sp_reg - 1'b1;
            default: sp_next = sp_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sp_reg        <= '0;
            dout_reg      <= '0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            sp_reg <= sp_next;
            if (rd_en) begin
                dout_reg <= rd_data;
            end
            if (ovf_set) begin
                overflow_reg <= 1'b1;
            end
            if (udf_set) begin
                underflow_reg <= 1'b1;
            end
        end
    end

    stack_regfile #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_regfile (
        .clk   (clk),
        .we    (wr_en && !rst),
        .waddr (wr_addr),
        .wdata (din),
        .raddr (top_addr),
        .rdata (rd_data)
    );

endmodule

// File: tb/tb_stack_unit.sv
// Directed bench for stack_unit: each task drives one scenario and checks
// outputs one time unit after the active edge against hand-computed values.
module tb_stack_unit;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       push = 1'b0;
    logic       pop = 1'b0;
    logic       tos = 1'b0;
    logic [7:0] din = 8'h00;
    logic [7:0] dout;
    logic [4:0] count;
    logic       empty;
    logic       full;
    logic       overflow;
    logic       underflow;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    stack_unit #(.DATA_W(8), .ADDR_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .tos       (tos),
        .din       (din),
        .dout      (dout),
        .count     (count),
        .empty     (empty),
        .full      (full),
        .overflow  (overflow),
        .underflow (underflow)
    );

    task automatic cyc(input logic r, input logic p, input logic o, input logic t, input logic [7:0] d);
        rst = r; push = p; pop = o; tos = t; din = d;
        @(posedge clk);
        #1;
        rst = 1'b0; push = 1'b0; pop = 1'b0; tos = 1'b0; din = 8'h00;
        $display("txn rst=%0b push=%0b pop=%0b tos=%0b din=%02h -> dout=%02h count=%0d empty=%0b full=%0b ovf=%0b udf=%0b",
                 r, p, o, t, d, dout, count, empty, full, overflow, underflow);
    endtask

    task automatic test_reset();
        cyc(1, 0, 0, 0, 8'h00);
        n_checks++; if (count !== 5'd0)  begin n_fail++; $display("FAIL reset_count got=%0d exp=0", count); end
        n_checks++; if (empty !== 1'b1)  begin n_fail++; $display("FAIL reset_empty got=%0b exp=1", empty); end
        n_checks++; if (full !== 1'b0)   begin n_fail++; $display("FAIL reset_full got=%0b exp=0", full); end
        n_checks++; if (dout !== 8'h00)  begin n_fail++; $display("FAIL reset_dout got=%02h exp=00", dout); end
        n_checks++; if (overflow !== 1'b0)  begin n_fail++; $display("FAIL reset_ovf got=%0b exp=0", overflow); end
        n_checks++; if (underflow !== 1'b0) begin n_fail++; $display("FAIL reset_udf got=%0b exp=0", underflow); end
    endtask

    task automatic test_lifo();
        logic [7:0] exp_d [3] = '{8'h33, 8'h22, 8'h11};
        cyc(1, 0, 0, 0, 8'h00);
        cyc(0, 1, 0, 0, 8'h11);
        cyc(0, 1, 0, 0, 8'h22);
        cyc(0, 1, 0, 0, 8'h33);
        n_checks++; if (count !== 5'd3) begin n_fail++; $display("FAIL lifo_fill_count got=%0d exp=3", count); end
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 1, 0, 8'h00);
            n_checks++; if (dout !== exp_d[i]) begin n_fail++; $display("FAIL lifo_pop%0d_dout got=%02h exp=%02h", i, dout, exp_d[i]); end
            n_checks++; if (count !== 5'(2 - i)) begin n_fail++; $display("FAIL lifo_pop%0d_count got=%0d exp=%0d", i, count, 2 - i); end
            cyc(0, 0, 0, 0, 8'h00);
            n_checks++; if (dout !== exp_d[i]) begin n_fail++; $display("FAIL lifo_hold%0d_dout got=%02h exp=%02h", i, dout, exp_d[i]); end
        end
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL lifo_empty got=%0b exp=1", empty); end
    endtask

    task automatic test_overflow();
        cyc(1, 0, 0, 0, 8'h00);
        for (int i = 0; i < 16; i++) cyc(0, 1, 0, 0, 8'(i));
        n_checks++; if (full !== 1'b1)     begin n_fail++; $display("FAIL ovf_full got=%0b exp=1", full); end
        n_checks++; if (count !== 5'd16)   begin n_fail++; $display("FAIL ovf_count16 got=%0d exp=16", count); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_early got=%0b exp=0", overflow); end
        // Replace at full is legal: returns old top, keeps count, no overflow.
        cyc(0, 1, 1, 0, 8'h0F);
        n_checks++; if (dout !== 8'h0F)    begin n_fail++; $display("FAIL ovf_repl_dout got=%02h exp=0f", dout); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_repl_flag got=%0b exp=0", overflow); end
        cyc(0, 1, 0, 0, 8'hAA);
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag got=%0b exp=1", overflow); end
        n_checks++; if (count !== 5'd16)   begin n_fail++; $display("FAIL ovf_count_hold got=%0d exp=16", count); end
        cyc(0, 0, 1, 0, 8'h00);
        n_checks++; if (dout !== 8'h0F)    begin n_fail++; $display("FAIL ovf_pop1 got=%02h exp=0f", dout); end
        n_checks++; if (count !== 5'd15)   begin n_fail++; $display("FAIL ovf_pop_count got=%0d exp=15", count); end
        cyc(0, 0, 1, 0, 8'h00);
        n_checks++; if (dout !== 8'h0E)    begin n_fail++; $display("FAIL ovf_pop2 got=%02h exp=0e", dout); end
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got=%0b exp=1", overflow); end
    endtask

    task automatic test_underflow();
        cyc(1, 0, 0, 0, 8'h00);
        cyc(0, 0, 1, 0, 8'h00);
        n_checks++; if (underflow !== 1'b1) begin n_fail++; $display("FAIL udf_pop_flag got=%0b exp=1", underflow); end
        n_checks++; if (dout !== 8'h00)     begin n_fail++; $display("FAIL udf_pop_dout got=%02h exp=00", dout); end
        n_checks++; if (count !== 5'd0)     begin n_fail++; $display("FAIL udf_pop_count got=%0d exp=0", count); end
        cyc(0, 0, 0, 1, 8'h00);
        n_checks++; if (dout !== 8'h00)     begin n_fail++; $display("FAIL udf_tos_dout got=%02h exp=00", dout); end
        n_checks++; if (count !== 5'd0)     begin n_fail++; $display("FAIL udf_tos_count got=%0d exp=0", count); end
        cyc(0, 1, 0, 0, 8'h5C);
        cyc(0, 0, 0, 1, 8'h00);
        n_checks++; if (dout !== 8'h5C)     begin n_fail++; $display("FAIL udf_after_tos got=%02h exp=5c", dout); end
        n_checks++; if (underflow !== 1'b1) begin n_fail++; $display("FAIL udf_sticky got=%0b exp=1", underflow); end
        n_checks++; if (count !== 5'd1)     begin n_fail++; $display("FAIL udf_after_count got=%0d exp=1", count); end
        // push+pop on empty behaves as a push and flags underflow.
        cyc(1, 0, 0, 0, 8'h00);
        cyc(0, 1, 1, 0, 8'h66);
        n_checks++; if (count !== 5'd1)     begin n_fail++; $display("FAIL udf_pp_count got=%0d exp=1", count); end
        n_checks++; if (underflow !== 1'b1) begin n_fail++; $display("FAIL udf_pp_flag got=%0b exp=1", underflow); end
        n_checks++; if (dout !== 8'h00)     begin n_fail++; $display("FAIL udf_pp_dout got=%02h exp=00", dout); end
    endtask

    task automatic test_replace();
        cyc(1, 0, 0, 0, 8'h00);
        cyc(0, 1, 0, 0, 8'h40);
        cyc(0, 1, 0, 0, 8'h41);
        cyc(0, 1, 1, 0, 8'h99);
        n_checks++; if (dout !== 8'h41)  begin n_fail++; $display("FAIL repl_dout got=%02h exp=41", dout); end
        n_checks++; if (count !== 5'd2)  begin n_fail++; $display("FAIL repl_count got=%0d exp=2", count); end
        cyc(0, 0, 1, 0, 8'h00);
        n_checks++; if (dout !== 8'h99)  begin n_fail++; $display("FAIL repl_pop1 got=%02h exp=99", dout); end
        cyc(0, 0, 1, 0, 8'h00);
        n_checks++; if (dout !== 8'h40)  begin n_fail++; $display("FAIL repl_pop2 got=%02h exp=40", dout); end
        n_checks++; if (underflow !== 1'b0) begin n_fail++; $display("FAIL repl_udf got=%0b exp=0", underflow); end
    endtask

    task automatic test_tos();
        cyc(1, 0, 0, 0, 8'h00);
        cyc(0, 1, 0, 0, 8'h07);
        for (int i = 0; i < 2; i++) begin
            cyc(0, 0, 0, 1, 8'h00);
            n_checks++; if (dout !== 8'h07) begin n_fail++; $display("FAIL tos%0d_dout got=%02h exp=07", i, dout); end
            n_checks++; if (count !== 5'd1) begin n_fail++; $display("FAIL tos%0d_count got=%0d exp=1", i, count); end
        end
        cyc(0, 1, 0, 1, 8'h08);
        n_checks++; if (dout !== 8'h07) begin n_fail++; $display("FAIL tos_push_dout got=%02h exp=07", dout); end
        n_checks++; if (count !== 5'd2) begin n_fail++; $display("FAIL tos_push_count got=%0d exp=2", count); end
        cyc(0, 0, 1, 0, 8'h00);
        n_checks++; if (dout !== 8'h08) begin n_fail++; $display("FAIL tos_push_pop got=%02h exp=08", dout); end
    endtask

    task automatic test_reset_mid();
        cyc(1, 0, 0, 0, 8'h00);
        cyc(0, 0, 1, 0, 8'h00);
        for (int i = 1; i <= 5; i++) cyc(0, 1, 0, 0, 8'(i));
        cyc(0, 0, 0, 1, 8'h00);
        n_checks++; if (dout !== 8'h05)  begin n_fail++; $display("FAIL mid_pre_dout got=%02h exp=05", dout); end
        n_checks++; if (count !== 5'd5)  begin n_fail++; $display("FAIL mid_pre_count got=%0d exp=5", count); end
        cyc(1, 1, 0, 0, 8'hEE);
        n_checks++; if (count !== 5'd0)     begin n_fail++; $display("FAIL mid_count got=%0d exp=0", count); end
        n_checks++; if (empty !== 1'b1)     begin n_fail++; $display("FAIL mid_empty got=%0b exp=1", empty); end
        n_checks++; if (dout !== 8'h00)     begin n_fail++; $display("FAIL mid_dout got=%02h exp=00", dout); end
        n_checks++; if (overflow !== 1'b0)  begin n_fail++; $display("FAIL mid_ovf got=%0b exp=0", overflow); end
        n_checks++; if (underflow !== 1'b0) begin n_fail++; $display("FAIL mid_udf got=%0b exp=0", underflow); end
    endtask

    initial begin
        test_reset();
        test_lifo();
        test_overflow();
        test_underflow();
        test_replace();
        test_tos();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
